// File: rtl/instruction_encoder_loader_pkg.sv
// rtl/instruction_encoder_loader_pkg.sv - shared formats, field widths and loader FSM encoding
package instruction_encoder_loader_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_RAW = 2'd3;

    localparam int OPCODE_W = 6;
    localparam int RS_W     = 5;
    localparam int RT_W     = 5;
    localparam int RD_W     = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JUMP_W   = 26;
    localparam int INST_W   = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [1:0]          fmt;
        logic [OPCODE_W-1:0] opcode;
        logic [RS_W-1:0]     rs;
        logic [RT_W-1:0]     rt;
        logic [RD_W-1:0]     rd;
        logic [SHAMT_W-1:0]  shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm;
        logic [JUMP_W-1:0]   jump;
        logic [INST_W-1:0]   raw;
    } inst_fields_t;

    // An R-format set must carry the SPECIAL opcode; anything else is a malformed request.
    function automatic logic is_bad_rtype(input logic [1:0] fmt, input logic [OPCODE_W-1:0] opcode);
        return (fmt == FMT_R) && (opcode != OP_RTYPE);
    endfunction

endpackage

// File: rtl/instruction_encoder_loader_field_encoder.sv
// rtl/instruction_encoder_loader_field_encoder.sv - combinational MIPS field set to instruction word packer
module instruction_field_encoder
    import instruction_encoder_loader_pkg::*;
(
    input  inst_fields_t        fields,
    output logic [INST_W-1:0]   word
);

    always_comb begin
        word = '0;
        case (fields.fmt)
            FMT_R:   word = {fields.opcode, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
            FMT_I:   word = {fields.opcode, fields.rs, fields.rt, fields.imm};
            FMT_J:   word = {fields.opcode, fields.jump};
            default: word = fields.raw;
        endcase
    end

endmodule

// File: rtl/instruction_encoder_loader.sv
// rtl/instruction_encoder_loader.sv - packs field sets into words and streams them into IMEM
module instruction_encoder_loader
    import instruction_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [RS_W-1:0]       rs,
    input  logic [RT_W-1:0]       rt,
    input  logic [RD_W-1:0]       rd,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [IMM_W-1:0]      imm,
    input  logic [JUMP_W-1:0]     jump,
    input  logic [INST_W-1:0]     raw,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [INST_W-1:0]     mem_wdata,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [INST_W-1:0]   mem_wdata_q, mem_wdata_d;

    inst_fields_t        fields;
    logic [INST_W-1:0]   enc_word;
    logic                accept;

    always_comb begin
        fields        = '0;
        fields.fmt    = fmt;
        fields.opcode = opcode;
        fields.rs     = rs;
        fields.rt     = rt;
        fields.rd     = rd;
        fields.shamt  = shamt;
        fields.funct  = funct;
        fields.imm    = imm;
        fields.jump   = jump;
        fields.raw    = raw;
    end

    instruction_field_encoder u_field_encoder (
        .fields (fields),
        .word   (enc_word)
    );

    assign full     = (count_q == DEPTH_CNT);
    assign in_ready = (state_q == ST_LOAD) && !full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // The write address is captured from the pre-increment index so a word
        // accepted alongside a restart still lands at its original slot.
        if (accept) begin
            mem_addr_d  = BASE_ADDR + (32'(index_q) << 2);
            mem_wdata_d = enc_word;
            index_d     = index_q + ADDR_W'(1);
            count_d     = count_q + (ADDR_W+1)'(1);
            if (is_bad_rtype(fmt, opcode)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                end else if (accept && (count_q == LAST_CNT)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                if (!mem_we_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A restart overrides both finish and the counter update of a same-cycle accept.
        if (start) begin
            state_d = ST_LOAD;
            index_d = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE) || mem_we_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb/tb_instruction_encoder_loader.sv - directed and randomized checks against a behavioural loader model
module tb_instruction_encoder_loader;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 2;
    localparam logic [31:0] BASE   = 32'h0;

    logic        clk;
    logic        rst;
    logic        start, finish, in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jump;
    logic [31:0] raw;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [ADDR_W:0] count;
    logic        busy, full, err;

    int tests = 0;
    int fails = 0;
    int writes_seen = 0;

    // model state: session accepting/full, draining, words counted, error flag, last write
    bit          m_open, m_drain, m_err, m_we;
    int          m_count;
    logic [31:0] m_addr, m_wdata;

    instruction_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .jump(jump), .raw(raw), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .busy(busy), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_encode();
        longint unsigned w;
        case (fmt)
            2'd0: w = longint'(opcode) * 64'd67108864 + longint'(rs) * 64'd2097152
                    + longint'(rt) * 64'd65536 + longint'(rd) * 64'd2048
                    + longint'(shamt) * 64'd64 + longint'(funct);
            2'd1: w = longint'(opcode) * 64'd67108864 + longint'(rs) * 64'd2097152
                    + longint'(rt) * 64'd65536 + longint'(imm);
            2'd2: w = longint'(opcode) * 64'd67108864 + longint'(jump);
            default: w = longint'(raw);
        endcase
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_open = 0; m_drain = 0; m_err = 0; m_we = 0; m_count = 0;
        m_addr = BASE; m_wdata = 32'h0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".mem_we"}, 32'(mem_we), 32'(m_we));
        chk({where, ".count"},  32'(count), 32'(m_count));
        chk({where, ".full"},   32'(full), 32'(m_count == DEPTH));
        chk({where, ".err"},    32'(err), 32'(m_err));
        chk({where, ".busy"},   32'(busy), 32'(m_open || m_drain || m_we));
        if (m_we) begin
            chk({where, ".mem_addr"},  mem_addr, m_addr);
            chk({where, ".mem_wdata"}, mem_wdata, m_wdata);
        end
    endtask

    task automatic step(input string where);
        bit acc, old_we;
        chk({where, ".in_ready"}, 32'(in_ready), 32'(m_open && (m_count < DEPTH)));
        acc    = in_valid && m_open && (m_count < DEPTH);
        old_we = m_we;
        m_we   = acc;
        if (acc) begin
            m_addr  = BASE + 32'(4 * m_count);
            m_wdata = ref_encode();
        end
        if (start) begin
            m_count = 0; m_err = 0; m_open = 1; m_drain = 0;
        end else begin
            if (acc) begin
                m_count++;
                if (fmt == 2'd0 && opcode != 6'd0) m_err = 1;
            end
            if (m_open && finish) begin
                m_open = 0; m_drain = 1;
            end else if (m_drain && !old_we) begin
                m_drain = 0;
            end
        end
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) writes_seen++;
        check_outputs(where);
    endtask

    task automatic idle_inputs();
        start = 0; finish = 0; in_valid = 0;
        fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0;
        imm = 0; jump = 0; raw = 0;
    endtask

    task automatic rand_fields();
        fmt = 2'($urandom); opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
        rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
        imm = 16'($urandom); jump = 26'($urandom); raw = $urandom;
        if ($urandom_range(0, 1) == 0) opcode = 6'd0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        chk("reset.mem_addr", mem_addr, BASE);
        chk("reset.mem_wdata", mem_wdata, 32'h0);
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. R pack
        start = 1; step("t1.start"); start = 0;
        in_valid = 1; fmt = 2'd0; opcode = 6'h00; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20;
        step("t1.r");
        chk("t1.wdata_const", mem_wdata, 32'h00221820);
        chk("t1.addr_const", mem_addr, 32'h0);

        // 2. I then J pack
        fmt = 2'd1; opcode = 6'h08; imm = 16'hFFFF;
        step("t2.i");
        chk("t2.i_wdata_const", mem_wdata, 32'h2022FFFF);
        chk("t2.i_addr_const", mem_addr, 32'h4);
        fmt = 2'd2; opcode = 6'h02; jump = 26'h0000010;
        step("t2.j");
        chk("t2.j_wdata_const", mem_wdata, 32'h08000010);
        chk("t2.j_addr_const", mem_addr, 32'h8);

        // 3. fill to DEPTH with six back-to-back sets
        in_valid = 0; start = 1; step("t3.start"); start = 0;
        writes_seen = 0;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            step("t3.stream");
        end
        chk("t3.writes", 32'(writes_seen), 32'd4);
        chk("t3.full_const", 32'(full), 32'd1);
        chk("t3.in_ready_const", 32'(in_ready), 32'd0);
        in_valid = 0; finish = 1; step("t3.finish"); finish = 0;
        step("t3.drain");
        step("t3.idle");

        // 4. restart in the same cycle as an accept
        start = 1; step("t4.start"); start = 0;
        in_valid = 1; fmt = 2'd3;
        raw = 32'hA0000000; step("t4.w0");
        raw = 32'hA0000001; step("t4.w1");
        raw = 32'hA0000002; start = 1; step("t4.restart"); start = 0;
        chk("t4.old_addr_const", mem_addr, 32'h8);
        chk("t4.cleared_count", 32'(count), 32'd0);
        raw = 32'hA0000003; step("t4.after");
        chk("t4.new_addr_const", mem_addr, 32'h0);
        chk("t4.new_count_const", 32'(count), 32'd1);

        // 5. sticky error flag
        fmt = 2'd0; opcode = 6'h23; step("t5.bad_r");
        chk("t5.err_const", 32'(err), 32'd1);
        chk("t5.written_const", 32'(mem_we), 32'd1);
        in_valid = 0; finish = 1; step("t5.finish"); finish = 0;
        step("t5.hold1");
        step("t5.hold2");
        chk("t5.err_held", 32'(err), 32'd1);
        start = 1; step("t5.restart"); start = 0;
        chk("t5.err_cleared", 32'(err), 32'd0);

        // 6. asynchronous reset while a write is in flight
        in_valid = 1; fmt = 2'd3; raw = 32'h12345678; step("t6.write");
        #1 rst = 1'b1;
        #1;
        chk("t6.mem_we", 32'(mem_we), 32'd0);
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        model_reset();
        idle_inputs();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("t6.after");

        // randomized sessions
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            start    = ($urandom_range(0, 19) == 0);
            finish   = ($urandom_range(0, 14) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
